// File: rtl/gpio_in_cond.sv
// GPIO input conditioning: 2-flop synchroniser, per-pin debounce, edge capture
// into sticky W1C status with a level interrupt, configured over APB.
module gpio_in_cond #(
  parameter int GPIO_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [15:0]           paddr,
  input  logic                  pwrite,
  input  logic                  psel,
  input  logic                  penable,
  output logic [31:0]           prdata,
  input  logic [31:0]           pwdata,
  input  logic [GPIO_WIDTH-1:0] pad_in,
  output logic [GPIO_WIDTH-1:0] gpi,
  output logic                  irq
);

  localparam logic [2:0] A_DEBOUNCE = 3'd0;
  localparam logic [2:0] A_RISE_EN  = 3'd1;
  localparam logic [2:0] A_FALL_EN  = 3'd2;
  localparam logic [2:0] A_STATUS   = 3'd3;
  localparam logic [2:0] A_LEVEL    = 3'd4;

  logic [CNT_WIDTH-1:0]  debounce_q, debounce_d;
  logic [GPIO_WIDTH-1:0] rise_en_q, rise_en_d;
  logic [GPIO_WIDTH-1:0] fall_en_q, fall_en_d;
  logic [GPIO_WIDTH-1:0] status_q, status_d;

  logic [GPIO_WIDTH-1:0] s1_q, s2_q;
  logic [GPIO_WIDTH-1:0] stb_q, stb_d;
  logic [CNT_WIDTH-1:0]  cnt_q [GPIO_WIDTH];
  logic [CNT_WIDTH-1:0]  cnt_d [GPIO_WIDTH];

  logic                  wr_en;
  logic [2:0]            wr_sel;
  logic [GPIO_WIDTH-1:0] edge_set;
  logic [GPIO_WIDTH-1:0] w1c_mask;
  logic                  unused_bits;

  assign wr_en  = psel & penable & pwrite;
  assign wr_sel = paddr[4:2];

  // Only word offsets 0x00-0x1C are decoded; the rest of the bus is ignored.
  assign unused_bits = ^{paddr[15:5], paddr[1:0], pwdata};

  always_comb begin
    for (int i = 0; i < GPIO_WIDTH; i++) begin
      stb_d[i] = stb_q[i];
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == stb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= debounce_q) begin
        stb_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  assign edge_set = (stb_d & ~stb_q & rise_en_q) | (~stb_d & stb_q & fall_en_q);

  always_comb begin
    debounce_d = debounce_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    w1c_mask   = '0;
    if (wr_en) begin
      case (wr_sel)
        A_DEBOUNCE: debounce_d = pwdata[CNT_WIDTH-1:0];
        A_RISE_EN:  rise_en_d  = pwdata[GPIO_WIDTH-1:0];
        A_FALL_EN:  fall_en_d  = pwdata[GPIO_WIDTH-1:0];
        A_STATUS:   w1c_mask   = pwdata[GPIO_WIDTH-1:0];
        default:    ;
      endcase
    end
    // A new edge in the same cycle as a W1C keeps the bit set.
    status_d = (status_q & ~w1c_mask) | edge_set;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_q       <= '0;
      s2_q       <= '0;
      stb_q      <= '0;
      debounce_q <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      status_q   <= '0;
      for (int i = 0; i < GPIO_WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q       <= pad_in;
      s2_q       <= s1_q;
      stb_q      <= stb_d;
      debounce_q <= debounce_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      status_q   <= status_d;
      for (int i = 0; i < GPIO_WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    prdata = '0;
    if (psel) begin
      case (paddr[4:2])
        A_DEBOUNCE: prdata = 32'(debounce_q);
        A_RISE_EN:  prdata = 32'(rise_en_q);
        A_FALL_EN:  prdata = 32'(fall_en_q);
        A_STATUS:   prdata = 32'(status_q);
        A_LEVEL:    prdata = 32'(stb_q);
        default:    prdata = '0;
      endcase
    end
  end

  assign gpi = stb_q;
  assign irq = |status_q;

endmodule

// File: tb/tb_gpio_in_cond.sv
// Bench for gpio_in_cond: directed corner sequences, an APB map table, and a
// randomized run against a sample-window reference model.
module tb_gpio_in_cond;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] paddr;
  logic        pwrite, psel, penable;
  logic [31:0] prdata, pwdata;
  logic [3:0]  pad_in;
  logic [3:0]  gpi;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  gpio_in_cond #(.GPIO_WIDTH(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .resetn(resetn), .paddr(paddr), .pwrite(pwrite), .psel(psel),
    .penable(penable), .prdata(prdata), .pwdata(pwdata), .pad_in(pad_in),
    .gpi(gpi), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] off;
    logic [31:0] exp;
  } map_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
    paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [15:0] a, output logic [31:0] d);
    paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    #1;
    d = prdata;
    psel = 1'b0;
  endtask

  // Reference model: a pin's conditioned level flips once the last DEBOUNCE+1
  // synchronised samples all differ from it.
  bit [3:0] m_s1, m_s2, m_stb, m_st, m_rise, m_fall;
  bit       hist [4][32];
  int       m_deb;

  task automatic model_step(input logic [3:0] pad, input logic [3:0] w1c);
    bit [3:0] set;
    bit flip;
    set = '0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 31; k > 0; k--) hist[i][k] = hist[i][k-1];
      hist[i][0] = m_s2[i];
      flip = 1'b1;
      for (int k = 0; k <= m_deb; k++) if (hist[i][k] == m_stb[i]) flip = 1'b0;
      if (flip) begin
        if (!m_stb[i] && m_rise[i]) set[i] = 1'b1;
        if (m_stb[i] && m_fall[i]) set[i] = 1'b1;
        m_stb[i] = ~m_stb[i];
      end
    end
    m_st = (m_st & ~w1c) | set;
    m_s2 = m_s1;
    m_s1 = pad;
  endtask

  initial begin
    logic [31:0] rd;
    logic saw;
    logic [3:0] w1c;
    map_vec_t map_tbl [8];

    map_tbl[0] = '{16'h00, 32'h0000_FFFF};
    map_tbl[1] = '{16'h04, 32'h0000_000F};
    map_tbl[2] = '{16'h08, 32'h0000_000F};
    map_tbl[3] = '{16'h0C, 32'h0000_0000};
    map_tbl[4] = '{16'h10, 32'h0000_0001};
    map_tbl[5] = '{16'h14, 32'h0000_0000};
    map_tbl[6] = '{16'h18, 32'h0000_0000};
    map_tbl[7] = '{16'h1C, 32'h0000_0000};

    resetn = 1'b0; pad_in = 4'h0; paddr = '0; pwdata = '0;
    pwrite = 1'b0; psel = 1'b0; penable = 1'b0;

    // Reset values
    #1;
    check("rst_gpi", 32'(gpi), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_prdata", prdata, 32'h0);
    tick(2);
    resetn = 1'b1;
    tick(1);

    // Mid-run reset with pads high
    pad_in = 4'hF;
    tick(5);
    check("pre_rst_gpi", 32'(gpi), 32'hF);
    resetn = 1'b0;
    #1;
    check("async_rst_gpi", 32'(gpi), 32'h0);
    check("async_rst_irq", 32'(irq), 32'h0);
    apb_read(16'h0C, rd);
    check("async_rst_status", rd, 32'h0);
    tick(2);
    resetn = 1'b1;
    tick(2);
    check("post_rst_gpi_e2", 32'(gpi), 32'h0);
    tick(1);
    check("post_rst_gpi_e3", 32'(gpi), 32'hF);

    // Debounce of 5: rise 8 edges after first sampling edge
    pad_in = 4'h0;
    tick(5);
    apb_write(16'h00, 32'd5);
    apb_write(16'h04, 32'h1);
    tick(10);
    check("deb_idle_gpi", 32'(gpi), 32'h0);
    pad_in[0] = 1'b1;
    tick(7);
    check("deb_e7_gpi0", 32'(gpi[0]), 32'h0);
    check("deb_e7_irq", 32'(irq), 32'h0);
    tick(1);
    check("deb_e8_gpi0", 32'(gpi[0]), 32'h1);
    check("deb_e8_irq", 32'(irq), 32'h1);
    apb_read(16'h0C, rd);
    check("deb_status", rd, 32'h1);
    apb_write(16'h0C, 32'h1);
    apb_read(16'h0C, rd);
    check("w1c_status", rd, 32'h0);
    check("w1c_irq", 32'(irq), 32'h0);

    // Glitch rejection on pin 1
    apb_write(16'h04, 32'h3);
    pad_in[1] = 1'b1;
    tick(4);
    pad_in[1] = 1'b0;
    saw = 1'b0;
    repeat (14) begin tick(1); saw |= gpi[1]; end
    check("glitch4_gpi1", 32'(saw), 32'h0);
    apb_read(16'h0C, rd);
    check("glitch4_status", rd, 32'h0);
    pad_in[1] = 1'b1;
    tick(7);
    pad_in[1] = 1'b0;
    saw = 1'b0;
    repeat (20) begin tick(1); saw |= gpi[1]; end
    check("pulse7_gpi1_seen", 32'(saw), 32'h1);
    check("pulse7_gpi1_end", 32'(gpi[1]), 32'h0);
    apb_read(16'h0C, rd);
    check("pulse7_status", rd, 32'h2);
    apb_write(16'h0C, 32'h2);

    // Falling-edge capture and masking
    apb_write(16'h00, 32'd0);
    apb_write(16'h04, 32'h0);
    apb_write(16'h08, 32'h4);
    pad_in[3:2] = 2'b11;
    tick(5);
    apb_read(16'h0C, rd);
    check("fall_after_rise_status", rd, 32'h0);
    check("fall_level", 32'(gpi), 32'hD);
    pad_in[3:2] = 2'b00;
    tick(5);
    apb_read(16'h0C, rd);
    check("fall_status", rd, 32'h4);
    check("fall_irq", 32'(irq), 32'h1);
    apb_write(16'h0C, 32'hF);
    apb_read(16'h0C, rd);
    check("fall_clear", rd, 32'h0);

    // Set/clear collision on pin 0
    apb_write(16'h04, 32'h1);
    apb_write(16'h08, 32'h0);
    pad_in[0] = 1'b0;
    tick(5);
    pad_in[0] = 1'b1;
    tick(5);
    apb_read(16'h0C, rd);
    check("coll_pre_status", rd, 32'h1);
    pad_in[0] = 1'b0;
    tick(5);
    pad_in[0] = 1'b1;
    tick(1);
    apb_write(16'h0C, 32'h1);
    check("coll_gpi0", 32'(gpi[0]), 32'h1);
    apb_read(16'h0C, rd);
    check("coll_status", rd, 32'h1);
    apb_write(16'h0C, 32'h1);
    apb_read(16'h0C, rd);
    check("coll_after_clear", rd, 32'h0);

    // Lowering DEBOUNCE below a running count
    apb_write(16'h00, 32'd10);
    pad_in[3] = 1'b1;
    tick(6);
    apb_write(16'h00, 32'd2);
    check("debchg_e8_gpi3", 32'(gpi[3]), 32'h0);
    tick(1);
    check("debchg_e9_gpi3", 32'(gpi[3]), 32'h1);
    pad_in[3] = 1'b0;
    tick(8);

    // APB register map
    for (int i = 0; i < 8; i++) apb_write(map_tbl[i].off, 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) begin
      apb_read(map_tbl[i].off, rd);
      check($sformatf("map_0x%02h", map_tbl[i].off), rd, map_tbl[i].exp);
    end
    paddr = 16'h00; psel = 1'b0;
    #1;
    check("map_psel_low", prdata, 32'h0);

    // Randomized run against the reference model
    pad_in = 4'h0;
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    m_deb  = $urandom_range(0, 4);
    m_rise = 4'($urandom_range(0, 15));
    m_fall = 4'($urandom_range(0, 15));
    apb_write(16'h00, 32'(m_deb));
    apb_write(16'h04, 32'(m_rise));
    apb_write(16'h08, 32'(m_fall));
    tick(4);
    m_s1 = '0; m_s2 = '0; m_stb = '0; m_st = '0;
    for (int i = 0; i < 4; i++) for (int k = 0; k < 32; k++) hist[i][k] = 1'b0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 3) == 0) pad_in[i] = ~pad_in[i];
      paddr = 16'h0C; psel = 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        pwdata = $urandom; pwrite = 1'b1; penable = 1'b1; w1c = pwdata[3:0];
      end else begin
        pwrite = 1'b0; penable = 1'b0; w1c = 4'h0;
      end
      @(posedge clk);
      model_step(pad_in, w1c);
      #1;
      check("rand_gpi", 32'(gpi), 32'(m_stb));
      check("rand_irq", 32'(irq), 32'(|m_st));
      pwrite = 1'b0; penable = 1'b0;
      #1;
      check("rand_status", prdata, 32'(m_st));
    end
    psel = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
